// File: rtl/icb_arb_pkg.sv
// ----------------------------------------------------------------------------
// icb_arb_pkg
// Shared types, widths and helpers for the ICB N-to-1 arbiter.
//   ICB_ADDR_W / ICB_DATA_W / ICB_MASK_W : ICB command field widths
//   MAX_MST                              : largest supported master count
//   arb_state_e                          : command FSM state encoding
//   rr_pick()                            : search-from-pointer winner select
// ----------------------------------------------------------------------------
package icb_arb_pkg;

    localparam int ICB_ADDR_W = 32;
    localparam int ICB_DATA_W = 64;
    localparam int ICB_MASK_W = 8;
    localparam int MAX_MST    = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Returns the first asserted valid found by searching upward from ptr
    // and wrapping at num. Returns 0 when nothing is valid; callers qualify
    // the result with the valid bit of the returned index.
    function automatic int rr_pick(input logic [MAX_MST-1:0] valid,
                                   input int ptr,
                                   input int num);
        int pick;
        int idx;
        pick = 0;
        // Walk offsets from the far end down so the smallest offset wins.
        for (int i = MAX_MST - 1; i >= 0; i--) begin
            if (i < num) begin
                idx = (ptr + i) % num;
                if (valid[idx[2:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/icb_arb_id_fifo.sv
// ----------------------------------------------------------------------------
// icb_arb_id_fifo
// In-order FIFO of master indices; one entry per outstanding command.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (empties FIFO)
//   i_push, i_push_id : write an index (caller never pushes when full)
//   i_pop             : drop the head entry (caller never pops when empty)
//   o_full, o_empty   : occupancy flags
//   o_head            : index at the head of the FIFO
// ----------------------------------------------------------------------------
module icb_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_id,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_id;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/icb_arbiter.sv
// ----------------------------------------------------------------------------
// icb_arbiter
// Shares one downstream ICB slave port between NUM_MST upstream masters.
// Command channel: round-robin winner select (0-cycle latency), held via a
// LOCK state until the downstream handshake. Responses are routed back in
// order through an index FIFO of OUTST_DEPTH entries.
// Build option: define ICB_ARB_FIXED_PRIO_EN for fixed priority (master 0
// highest, no round-robin pointer).
// Handshake rule: a transfer happens on any cycle where valid && ready are
// both high at posedge clk; valid never depends on ready on the same side.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   m_icb_cmd_*           : packed per-master command channels
//   m_icb_rsp_*           : per-master response valid/ready, shared data/err
//   s_icb_cmd_*           : muxed downstream command channel
//   s_icb_rsp_*           : downstream response channel
//   o_dbg_state           : command FSM state
// ----------------------------------------------------------------------------
module icb_arbiter
    import icb_arb_pkg::*;
#(
    parameter int NUM_MST     = 2,
    parameter int OUTST_DEPTH = 4,
    parameter int MST_IDX_W   = $clog2(NUM_MST)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MST-1:0]            m_icb_cmd_valid,
    output logic [NUM_MST-1:0]            m_icb_cmd_ready,
    input  logic [NUM_MST*ICB_ADDR_W-1:0] m_icb_cmd_addr,
    input  logic [NUM_MST-1:0]            m_icb_cmd_read,
    input  logic [NUM_MST*ICB_DATA_W-1:0] m_icb_cmd_wdata,
    input  logic [NUM_MST*ICB_MASK_W-1:0] m_icb_cmd_wmask,
    output logic [NUM_MST-1:0]            m_icb_rsp_valid,
    input  logic [NUM_MST-1:0]            m_icb_rsp_ready,
    output logic [ICB_DATA_W-1:0]         m_icb_rsp_rdata,
    output logic                          m_icb_rsp_err,
    output logic                          s_icb_cmd_valid,
    input  logic                          s_icb_cmd_ready,
    output logic [ICB_ADDR_W-1:0]         s_icb_cmd_addr,
    output logic                          s_icb_cmd_read,
    output logic [ICB_DATA_W-1:0]         s_icb_cmd_wdata,
    output logic [ICB_MASK_W-1:0]         s_icb_cmd_wmask,
    input  logic                          s_icb_rsp_valid,
    output logic                          s_icb_rsp_ready,
    input  logic [ICB_DATA_W-1:0]         s_icb_rsp_rdata,
    input  logic                          s_icb_rsp_err,
    output arb_state_e                    o_dbg_state
);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [MST_IDX_W-1:0] r_grant_idx;
    logic [MST_IDX_W-1:0] w_pick;
    logic [MST_IDX_W-1:0] w_sel;
    logic [MST_IDX_W-1:0] w_head;
    logic [MAX_MST-1:0]   w_valid_ext;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_cmd_valid;
    logic                 w_cmd_hs;
    logic                 w_rsp_hs;

    always_comb begin
        w_valid_ext                = '0;
        w_valid_ext[NUM_MST-1:0]   = m_icb_cmd_valid;
    end

`ifdef ICB_ARB_FIXED_PRIO_EN
    assign w_pick = MST_IDX_W'(rr_pick(w_valid_ext, 0, NUM_MST));
`else
    logic [MST_IDX_W-1:0] r_rr_ptr;

    assign w_pick = MST_IDX_W'(rr_pick(w_valid_ext, int'(r_rr_ptr), NUM_MST));

    // Pointer moves to one past the master that just completed a command.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_cmd_hs) begin
            r_rr_ptr <= (w_sel == MST_IDX_W'(NUM_MST - 1)) ? '0 : w_sel + 1'b1;
        end
    end
`endif

    // ---------------- command FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_grant_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB_IDLE && w_cmd_valid && !s_icb_cmd_ready) begin
                r_grant_idx <= w_pick;
            end
        end
    end

    // ---------------- command FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_cmd_valid && !s_icb_cmd_ready) w_state_nxt = ARB_LOCK;
            ARB_LOCK: if (w_cmd_hs)                        w_state_nxt = ARB_IDLE;
            default:                                       w_state_nxt = ARB_IDLE;
        endcase
    end

    // ---------------- command FSM: outputs ----------------
    // In IDLE the pick's own valid bit equals "any valid" because the pick
    // lands on an asserted bit whenever one exists. Full FIFO blocks issue
    // even if a pop is happening now, keeping rsp out of the cmd path.
    always_comb begin
        w_sel       = (r_state == ARB_LOCK) ? r_grant_idx : w_pick;
        w_cmd_valid = !rst && !w_full && m_icb_cmd_valid[w_sel];
        o_dbg_state = r_state;
    end

    assign w_cmd_hs        = w_cmd_valid && s_icb_cmd_ready;
    assign s_icb_cmd_valid = w_cmd_valid;
    assign s_icb_cmd_addr  = m_icb_cmd_addr[int'(w_sel)*ICB_ADDR_W +: ICB_ADDR_W];
    assign s_icb_cmd_read  = m_icb_cmd_read[w_sel];
    assign s_icb_cmd_wdata = m_icb_cmd_wdata[int'(w_sel)*ICB_DATA_W +: ICB_DATA_W];
    assign s_icb_cmd_wmask = m_icb_cmd_wmask[int'(w_sel)*ICB_MASK_W +: ICB_MASK_W];

    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            m_icb_cmd_ready[i] = w_cmd_hs && (w_sel == MST_IDX_W'(i));
        end
    end

    // ---------------- response routing ----------------
    icb_arb_id_fifo #(
        .DEPTH (OUTST_DEPTH),
        .W     (MST_IDX_W)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_cmd_hs),
        .i_push_id (w_sel),
        .i_pop     (w_rsp_hs),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_head    (w_head)
    );

    // Empty FIFO means nothing is owed; a stray downstream response is
    // neither accepted nor forwarded.
    assign s_icb_rsp_ready = !rst && !w_empty && m_icb_rsp_ready[w_head];
    assign w_rsp_hs        = s_icb_rsp_valid && s_icb_rsp_ready;
    assign m_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m_icb_rsp_err   = s_icb_rsp_err;

    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            m_icb_rsp_valid[i] = !rst && !w_empty && s_icb_rsp_valid &&
                                 (w_head == MST_IDX_W'(i));
        end
    end

endmodule

// File: tb/tb_icb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_icb_arbiter
// Randomized and directed stimulus for icb_arbiter, checked every cycle
// against a transaction-level model (winner search, lock flag, queue of
// outstanding master indices).
// ----------------------------------------------------------------------------
module tb_icb_arbiter;
    import icb_arb_pkg::*;

    localparam int NUM_MST     = 2;
    localparam int OUTST_DEPTH = 4;
    localparam int MST_IDX_W   = $clog2(NUM_MST);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [NUM_MST-1:0]            m_icb_cmd_valid;
    logic [NUM_MST-1:0]            m_icb_cmd_ready;
    logic [NUM_MST*ICB_ADDR_W-1:0] m_icb_cmd_addr;
    logic [NUM_MST-1:0]            m_icb_cmd_read;
    logic [NUM_MST*ICB_DATA_W-1:0] m_icb_cmd_wdata;
    logic [NUM_MST*ICB_MASK_W-1:0] m_icb_cmd_wmask;
    logic [NUM_MST-1:0]            m_icb_rsp_valid;
    logic [NUM_MST-1:0]            m_icb_rsp_ready;
    logic [ICB_DATA_W-1:0]         m_icb_rsp_rdata;
    logic                          m_icb_rsp_err;
    logic                          s_icb_cmd_valid;
    logic                          s_icb_cmd_ready;
    logic [ICB_ADDR_W-1:0]         s_icb_cmd_addr;
    logic                          s_icb_cmd_read;
    logic [ICB_DATA_W-1:0]         s_icb_cmd_wdata;
    logic [ICB_MASK_W-1:0]         s_icb_cmd_wmask;
    logic                          s_icb_rsp_valid;
    logic                          s_icb_rsp_ready;
    logic [ICB_DATA_W-1:0]         s_icb_rsp_rdata;
    logic                          s_icb_rsp_err;
    arb_state_e                    o_dbg_state;

    icb_arbiter #(
        .NUM_MST     (NUM_MST),
        .OUTST_DEPTH (OUTST_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .m_icb_cmd_valid (m_icb_cmd_valid),
        .m_icb_cmd_ready (m_icb_cmd_ready),
        .m_icb_cmd_addr  (m_icb_cmd_addr),
        .m_icb_cmd_read  (m_icb_cmd_read),
        .m_icb_cmd_wdata (m_icb_cmd_wdata),
        .m_icb_cmd_wmask (m_icb_cmd_wmask),
        .m_icb_rsp_valid (m_icb_rsp_valid),
        .m_icb_rsp_ready (m_icb_rsp_ready),
        .m_icb_rsp_rdata (m_icb_rsp_rdata),
        .m_icb_rsp_err   (m_icb_rsp_err),
        .s_icb_cmd_valid (s_icb_cmd_valid),
        .s_icb_cmd_ready (s_icb_cmd_ready),
        .s_icb_cmd_addr  (s_icb_cmd_addr),
        .s_icb_cmd_read  (s_icb_cmd_read),
        .s_icb_cmd_wdata (s_icb_cmd_wdata),
        .s_icb_cmd_wmask (s_icb_cmd_wmask),
        .s_icb_rsp_valid (s_icb_rsp_valid),
        .s_icb_rsp_ready (s_icb_rsp_ready),
        .s_icb_rsp_rdata (s_icb_rsp_rdata),
        .s_icb_rsp_err   (s_icb_rsp_err),
        .o_dbg_state     (o_dbg_state)
    );

    // ---------------- master-side command holders ----------------
    bit                    pend  [NUM_MST];
    logic [ICB_ADDR_W-1:0] b_addr [NUM_MST];
    logic                  b_read [NUM_MST];
    logic [ICB_DATA_W-1:0] b_wdata[NUM_MST];
    logic [ICB_MASK_W-1:0] b_wmask[NUM_MST];

    // ---------------- reference model state ----------------
    int         md_ptr;
    bit         md_lock;
    int         md_grant;
    logic [7:0] exp_q[$];

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit roll(input int p);
        return $urandom_range(99, 0) < p;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic pack_cmds();
        for (int i = 0; i < NUM_MST; i++) begin
            m_icb_cmd_valid[i]                        = pend[i];
            m_icb_cmd_addr[i*ICB_ADDR_W +: ICB_ADDR_W] = b_addr[i];
            m_icb_cmd_read[i]                         = b_read[i];
            m_icb_cmd_wdata[i*ICB_DATA_W +: ICB_DATA_W] = b_wdata[i];
            m_icb_cmd_wmask[i*ICB_MASK_W +: ICB_MASK_W] = b_wmask[i];
        end
    endtask

    task automatic load_cmd(input int i, input logic [31:0] a, input logic rd,
                            input logic [63:0] wd, input logic [7:0] wm);
        pend[i]    = 1'b1;
        b_addr[i]  = a;
        b_read[i]  = rd;
        b_wdata[i] = wd;
        b_wmask[i] = wm;
    endtask

    task automatic set_slave(input bit srdy, input bit rspv, input logic [63:0] rdata,
                             input bit err, input logic [NUM_MST-1:0] mrdy);
        s_icb_cmd_ready = srdy;
        s_icb_rsp_valid = rspv;
        s_icb_rsp_rdata = rdata;
        s_icb_rsp_err   = err;
        m_icb_rsp_ready = mrdy;
    endtask

    // Pending commands stay put (ICB hold rule); idle masters may start one.
    task automatic drive_random(input int p_req, input int p_srdy, input int p_rspv, input int p_mrdy);
        logic [NUM_MST-1:0] mr;
        for (int i = 0; i < NUM_MST; i++) begin
            if (!pend[i] && roll(p_req)) begin
                load_cmd(i, $urandom, 1'($urandom_range(1, 0)), {$urandom, $urandom},
                         8'($urandom_range(255, 0)));
            end
            mr[i] = roll(p_mrdy);
        end
        pack_cmds();
        set_slave(roll(p_srdy), roll(p_rspv), {$urandom, $urandom}, roll(20), mr);
    endtask

    // ---------------- model evaluation + comparison ----------------
    task automatic model_check();
        int                 w;
        bit                 any;
        bit                 full;
        bit                 cmd_v;
        bit                 cmd_hs;
        bit                 rsp_rdy;
        bit                 rsp_hs;
        int                 h;
        logic [NUM_MST-1:0] e_cmd_rdy;
        logic [NUM_MST-1:0] e_rsp_v;

        full = (exp_q.size() == OUTST_DEPTH);
        any  = 1'b0;
        w    = 0;
        if (md_lock) begin
            w   = md_grant;
            any = pend[w];
        end else begin
            for (int k = 0; k < NUM_MST; k++) begin
                int c;
                c = (md_ptr + k) % NUM_MST;
                if (!any && pend[c]) begin
                    any = 1'b1;
                    w   = c;
                end
            end
        end
        cmd_v  = any && !full;
        cmd_hs = cmd_v && s_icb_cmd_ready;

        check("state", 64'(o_dbg_state), md_lock ? 64'(ARB_LOCK) : 64'(ARB_IDLE));
        check("s_cmd_valid", 64'(s_icb_cmd_valid), 64'(cmd_v));
        if (cmd_v) begin
            check("s_cmd_addr",  64'(s_icb_cmd_addr),  64'(b_addr[w]));
            check("s_cmd_read",  64'(s_icb_cmd_read),  64'(b_read[w]));
            check("s_cmd_wdata", s_icb_cmd_wdata,      b_wdata[w]);
            check("s_cmd_wmask", 64'(s_icb_cmd_wmask), 64'(b_wmask[w]));
        end
        e_cmd_rdy = '0;
        if (cmd_hs) e_cmd_rdy[w] = 1'b1;
        check("m_cmd_ready", 64'(m_icb_cmd_ready), 64'(e_cmd_rdy));

        h       = (exp_q.size() > 0) ? int'(exp_q[0]) : 0;
        rsp_rdy = (exp_q.size() > 0) && m_icb_rsp_ready[h];
        e_rsp_v = '0;
        if (exp_q.size() > 0 && s_icb_rsp_valid) e_rsp_v[h] = 1'b1;
        check("s_rsp_ready", 64'(s_icb_rsp_ready), 64'(rsp_rdy));
        check("m_rsp_valid", 64'(m_icb_rsp_valid), 64'(e_rsp_v));
        if (|e_rsp_v) begin
            check("m_rsp_rdata", m_icb_rsp_rdata,      s_icb_rsp_rdata);
            check("m_rsp_err",   64'(m_icb_rsp_err),   64'(s_icb_rsp_err));
        end
        rsp_hs = s_icb_rsp_valid && rsp_rdy;

        // advance model to the state after this posedge
        if (rsp_hs) void'(exp_q.pop_front());
        if (cmd_hs) begin
            exp_q.push_back(8'(w));
            pend[w] = 1'b0;
            md_lock = 1'b0;
`ifndef ICB_ARB_FIXED_PRIO_EN
            md_ptr  = (w + 1) % NUM_MST;
`endif
        end else if (cmd_v) begin
            md_lock  = 1'b1;
            md_grant = w;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int n, input int p_req, input int p_srdy,
                              input int p_rspv, input int p_mrdy);
        repeat (n) begin
            drive_random(p_req, p_srdy, p_rspv, p_mrdy);
            step();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !pend[0] && !pend[1]) break;
            drive_random(0, 100, 100, 100);
            step();
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_MST; i++) pend[i] = 1'b0;
        pack_cmds();
        set_slave(1'b0, 1'b0, '0, 1'b0, '0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        md_ptr   = 0;
        md_lock  = 1'b0;
        md_grant = 0;
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < NUM_MST; i++) begin
            pend[i] = 1'b0; b_addr[i] = '0; b_read[i] = 1'b0; b_wdata[i] = '0; b_wmask[i] = '0;
        end
        pack_cmds();
        set_slave(1'b0, 1'b0, '0, 1'b0, '0);
        md_ptr = 0; md_lock = 1'b0; md_grant = 0;
        @(posedge clk);
        #1;
        apply_reset();

        // reset state: all outputs low
        step();

        // single master write, then its response
        load_cmd(0, 32'h1000, 1'b0, 64'hA5A5, 8'hFF);
        pack_cmds();
        set_slave(1'b1, 1'b0, '0, 1'b0, '0);
        step();
        pack_cmds();
        set_slave(1'b0, 1'b1, 64'h1234, 1'b0, '1);
        step();

        // contention: both masters always requesting, slave always ready
        run_random(12, 100, 100, 100, 100);
        drain();

        // lock: m1 stalls 3 cycles while m0 waits, handshake on 4th
        load_cmd(1, 32'h2000, 1'b1, 64'h0, 8'h0);
        pack_cmds();
        set_slave(1'b0, 1'b0, '0, 1'b0, '1);
        step();
        load_cmd(0, 32'h3000, 1'b0, 64'hBEEF, 8'h0F);
        pack_cmds();
        step();
        step();
        set_slave(1'b1, 1'b0, '0, 1'b0, '1);
        step();
        drain();

        // outstanding/full: no responses until the FIFO fills and stalls
        run_random(8, 100, 100, 0, 100);
        check("fifo_full", 64'(exp_q.size()), 64'(OUTST_DEPTH));
        for (int k = 0; k < 4; k++) begin
            pack_cmds();
            set_slave(1'b1, 1'b1, 64'h11 * (k + 1), 1'b0, '1);
            step();
        end
        drain();

        // response backpressure with random master readiness
        run_random(60, 60, 70, 70, 40);
        drain();

        // reset with commands outstanding, then a stray response
        run_random(6, 100, 100, 0, 100);
        apply_reset();
        step();
        pack_cmds();
        set_slave(1'b0, 1'b1, 64'hDEAD, 1'b1, '1);
        step();

        // long random mix
        run_random(1500, 50, 60, 55, 70);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icb_arbiter.md
Name: icb_arbiter

Overview:
- N-to-1 ICB arbiter. Shares one downstream ICB slave port (e.g. the ICB-to-APB bridge) between NUM_MST upstream ICB masters.
- Command channel uses round-robin grant with a hold-until-handshake lock.
- An in-order ID FIFO routes each response back to the master that issued the command.
- Supports up to OUTST_DEPTH outstanding commands.

Parameters:
- NUM_MST, 2, number of upstream masters (2..8).
- OUTST_DEPTH, 4, max outstanding commands (power of 2, ≥2).
- MST_IDX_W, $clog2(NUM_MST), width of master index stored in the FIFO.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- m_icb_cmd_valid  in  NUM_MST  per-master command valid.
- m_icb_cmd_ready  out  NUM_MST  per-master command ready.
- m_icb_cmd_addr  in  NUM_MST*32  packed addresses; master i at [i*32+:32].
- m_icb_cmd_read  in  NUM_MST  1=read, 0=write.
- m_icb_cmd_wdata  in  NUM_MST*64  packed write data.
- m_icb_cmd_wmask  in  NUM_MST*8  packed byte masks.
- m_icb_rsp_valid  out  NUM_MST  per-master response valid.
- m_icb_rsp_ready  in  NUM_MST  per-master response ready.
- m_icb_rsp_rdata  out  64  shared read data; qualified by m_icb_rsp_valid[i].
- m_icb_rsp_err  out  1  shared error; qualified by m_icb_rsp_valid[i].
- s_icb_cmd_valid / s_icb_cmd_ready  out / in  1  downstream command handshake.
- s_icb_cmd_addr / read / wdata / wmask  out  32 / 1 / 64 / 8  muxed command fields.
- s_icb_rsp_valid / s_icb_rsp_ready  in / out  1  downstream response handshake.
- s_icb_rsp_rdata / s_icb_rsp_err  in  64 / 1  downstream response fields.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - rr_ptr=0, lock=0, grant_idx=0, FIFO empty.
  - All outputs 0: s_icb_cmd_valid, s_icb_rsp_ready, m_icb_cmd_ready, m_icb_rsp_valid.
  - An in-flight transaction is abandoned; a late s_icb_rsp_valid is not accepted (FIFO empty ⇒ rsp_ready=0).
- Command FSM, 2 states:
  - IDLE:
    - If FIFO not full and any m valid, pick the winner: first asserted valid searching from rr_ptr upward, wrapping.
    - Winner is muxed combinationally onto s_icb_cmd_* with s_icb_cmd_valid=1 in the same cycle (0-cycle arbitration latency).
    - If s_icb_cmd_ready=1 the handshake completes and the FSM stays in IDLE; otherwise go to LOCK and register grant_idx.
  - LOCK:
    - Mux is held on grant_idx regardless of other requests; m valid is held by ICB rules.
    - Return to IDLE on the s handshake.
  - m_icb_cmd_ready[i] = s_icb_cmd_ready & s_icb_cmd_valid & (selected==i). Non-selected readies are 0.
  - On every cmd handshake: push the winner index into the FIFO; rr_ptr = winner+1 mod NUM_MST.
  - FIFO full ⇒ s_icb_cmd_valid=0 and all m ready=0. Push is never allowed on a full FIFO, even with a same-cycle pop; this avoids a rsp→cmd combinational path.
- Response path:
  - h = FIFO head.
  - m_icb_rsp_valid[h] = s_icb_rsp_valid & !empty; all other m_icb_rsp_valid bits are 0.
  - s_icb_rsp_ready = m_icb_rsp_ready[h] & !empty.
  - rdata and err pass through combinationally (0 latency).
  - Pop on the s rsp handshake.
  - Empty ⇒ s_icb_rsp_ready=0; a stray s_icb_rsp_valid is ignored.
  - Simultaneous push and pop on a non-full FIFO: count unchanged, both pointers advance; pointers wrap modulo OUTST_DEPTH.
- Responses are strictly in order; the downstream slave must return responses in command order.

Optional Feature:
- ICB_ARB_FIXED_PRIO_EN defined:
  - Fixed priority, master 0 highest; rr_ptr is removed and the search always starts at 0.
  - LOCK behaviour is unchanged.
- Undefined: round-robin as described above.

Decomposition:
- Package icb_arb_pkg:
  - ICB_ADDR_W=32, ICB_DATA_W=64, ICB_MASK_W=8.
  - FSM enum arb_state_e {ARB_IDLE, ARB_LOCK}.
  - Function rr_pick(valid, ptr) returning the winner index.
- Sub-module icb_arb_id_fifo: synchronous FIFO of MST_IDX_W-bit entries, depth OUTST_DEPTH, with push/pop/full/empty/head.

Test Plan:
- Single master:
  - m0 write addr=0x1000, wdata=0xA5A5, wmask=0xFF, s ready=1 → s_icb_cmd_* matches in the same cycle, m_icb_cmd_ready[0]=1.
  - rsp err=0 → routed only to m0.
- Contention:
  - m0 and m1 both valid every cycle, slave always ready → grants alternate 0,1,0,1.
  - With ICB_ARB_FIXED_PRIO_EN → m0 is granted on every cycle.
- Lock:
  - m1 granted with s ready=0 for 3 cycles while m0 is valid → s_icb_cmd_addr stays m1's address; m0 ready=0; m1 handshakes on cycle 4.
- Outstanding/full:
  - Issue 4 commands (m0,m1,m0,m1) with no response → 5th request stalls with s_icb_cmd_valid=0.
  - Responses rdata=0x11,0x22,0x33,0x44 → delivered to m0,m1,m0,m1 in order.
  - After the first pop, the 5th command issues.
- Response backpressure:
  - Head=m1 with m_icb_rsp_ready[1]=0 for 2 cycles → s_icb_rsp_ready=0 and m_icb_rsp_valid[0]=0; pop occurs when ready rises.
- Reset mid-operation:
  - rst=1 with 2 outstanding → next cycle all outputs 0 and FIFO empty.
  - Stray s_icb_rsp_valid=1 → s_icb_rsp_ready=0 and not forwarded to any master.
